// File: rtl/ram_requester.sv
// ram_requester
// ----------------------------------------------------------------------------
// Initiator side of the CPU-to-RAM protocol. One instruction-fetch port and
// one data port compete for a single variable-latency RAM. The winner's
// request is registered onto ramREN/ramWEN/ramaddr/ramstore and held stable
// until the RAM reports ACCESS (completion), ERROR/FREE or a timeout (abort).
// The winning port sees its wait line drop for exactly that one cycle. A GAP
// cycle with both enables low follows every transaction.
//
// Ports:
//   CLK, RST            clock (rising edge), synchronous active-high reset
//   iREN, iaddr         instruction read request / word address
//   iwait, iload        instruction wait (low = done this cycle) / data
//   dREN, dWEN          data read / write request (write wins if both set)
//   daddr, dstore       data word address / write data
//   dwait, dload        data wait (low = done this cycle) / read data
//   ramREN, ramWEN      registered RAM enables (never both high)
//   ramaddr, ramstore   registered RAM address / write data
//   ramload, ramstate   RAM read data / status
//                       (ramstate: 0=FREE, 1=BUSY, 2=ACCESS, 3=ERROR)
//   err                 sticky abort flag, cleared only by RST
// ----------------------------------------------------------------------------
module ram_requester #(
    parameter int unsigned TIMEOUT = 64,
    parameter logic [31:0] BAD     = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    // Encoding of the port that won the previous arbitration.
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        GAP     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        ren_q, ren_d;
    logic        wen_q, wen_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] store_q, store_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        last_q, last_d;

    logic        access;
    logic        abort;
    logic        pend_i;
    logic        pend_d;
    logic        grant_d;
    logic [31:0] xfer_load;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= 32'd0;
            store_q <= 32'd0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
            last_q  <= GRANT_I;
        end else begin
            state_q <= state_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ren_d     = ren_q;
        wen_d     = wen_q;
        addr_d    = addr_q;
        store_d   = store_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        iwait     = 1'b1;
        dwait     = 1'b1;
        iload     = 32'd0;
        dload     = 32'd0;

        pend_i    = iREN;
        pend_d    = dREN | dWEN;
        // Data wins if it is alone, or on a tie when instruction won last.
        grant_d   = pend_d && (!pend_i || last_q == GRANT_I);

        // ACCESS beats a same-cycle timeout; FREE while serving means the RAM
        // dropped our request, which is treated like an error.
        access    = (ramstate == RS_ACCESS);
        abort     = !access && (ramstate == RS_ERROR || ramstate == RS_FREE ||
                                cnt_q == TIMEOUT_CNT);
        xfer_load = abort ? BAD : (ren_q ? ramload : 32'd0);

        case (state_q)
            IDLE: begin
                ren_d = 1'b0;
                wen_d = 1'b0;
                cnt_d = 8'd0;
                if (grant_d) begin
                    addr_d  = daddr;
                    last_d  = GRANT_D;
                    state_d = SERVE_D;
                    if (dWEN) begin
                        wen_d   = 1'b1;
                        store_d = dstore;
                    end else begin
                        ren_d = 1'b1;
                    end
                end else if (pend_i) begin
                    addr_d  = iaddr;
                    ren_d   = 1'b1;
                    last_d  = GRANT_I;
                    state_d = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (access || abort) begin
                    state_d = GAP;
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    cnt_d   = 8'd0;
                    if (abort) begin
                        err_d = 1'b1;
                    end
                    if (state_q == SERVE_I) begin
                        iwait = 1'b0;
                        iload = xfer_load;
                    end else begin
                        dwait = 1'b0;
                        dload = xfer_load;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Requesters must never see a completion while reset is applied.
        if (RST) begin
            iwait = 1'b1;
            dwait = 1'b1;
            iload = 32'd0;
            dload = 32'd0;
        end
    end

    assign ramREN   = ren_q;
    assign ramWEN   = wen_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ram_requester.sv
// Directed testbench for ram_requester. Inputs change 1 ns after the rising
// edge; combinational outputs are sampled a further 1 ns later.
module tb_ram_requester;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;
    localparam logic [31:0] BAD_VAL  = 32'hBAD1BAD1;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        err;

    int checks_q   = 0;
    int failures_q = 0;

    ram_requester #(
        .TIMEOUT (64),
        .BAD     (32'hBAD1BAD1)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .err      (err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_q++;
        if (got !== exp) begin
            failures_q++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int early;
        logic is_d;
        logic [31:0] exp_addr;

        RST = 1'b1; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0; ramload = '0; ramstate = RS_FREE;

        // Reset state
        tick(); tick();
        #1;
        chk("rst_iwait", 32'(iwait), 32'd1);
        chk("rst_dwait", 32'(dwait), 32'd1);
        chk("rst_iload", iload, 32'd0);
        chk("rst_dload", dload, 32'd0);
        chk("rst_ramREN", 32'(ramREN), 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Data read, 3 BUSY cycles then ACCESS
        RST = 1'b0; dREN = 1'b1; daddr = 32'h40;
        tick();
        chk("rd_ramREN", 32'(ramREN), 32'd1);
        chk("rd_ramWEN", 32'(ramWEN), 32'd0);
        chk("rd_ramaddr", ramaddr, 32'h40);
        ramstate = RS_BUSY; #1;
        chk("rd_dwait_busy", 32'(dwait), 32'd1);
        tick(); tick(); tick();
        ramstate = RS_ACCESS; ramload = 32'h1234_5678; #1;
        chk("rd_dwait_done", 32'(dwait), 32'd0);
        chk("rd_dload", dload, 32'h1234_5678);
        chk("rd_iwait", 32'(iwait), 32'd1);
        chk("rd_ramaddr_held", ramaddr, 32'h40);
        dREN = 1'b0;
        tick();
        ramstate = RS_FREE; ramload = '0; #1;
        chk("rd_gap_ramREN", 32'(ramREN), 32'd0);
        chk("rd_gap_dwait", 32'(dwait), 32'd1);
        tick();

        // Write wins over read; data held despite input changes
        dWEN = 1'b1; dREN = 1'b1; daddr = 32'h80; dstore = 32'hDEAD_BEEF;
        tick();
        chk("wr_ramWEN", 32'(ramWEN), 32'd1);
        chk("wr_ramREN", 32'(ramREN), 32'd0);
        chk("wr_ramstore", ramstore, 32'hDEAD_BEEF);
        chk("wr_ramaddr", ramaddr, 32'h80);
        ramstate = RS_BUSY; daddr = 32'h0; dstore = 32'h0;
        tick();
        chk("wr_ramstore_held", ramstore, 32'hDEAD_BEEF);
        chk("wr_ramaddr_held", ramaddr, 32'h80);
        ramstate = RS_ACCESS; ramload = 32'hFFFF_FFFF; #1;
        chk("wr_dwait_done", 32'(dwait), 32'd0);
        chk("wr_dload", dload, 32'd0);
        dWEN = 1'b0; dREN = 1'b0;
        tick();
        ramstate = RS_FREE; ramload = '0;
        tick();

        // Alternating grants from reset: D, I, D, I
        RST = 1'b1;
        tick();
        RST = 1'b0; iREN = 1'b1; dREN = 1'b1; daddr = 32'h100; iaddr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            is_d = (k % 2 == 0);
            exp_addr = is_d ? 32'h100 : 32'h200;
            tick();
            chk($sformatf("alt%0d_ramaddr", k), ramaddr, exp_addr);
            chk($sformatf("alt%0d_ramREN", k), 32'(ramREN), 32'd1);
            ramstate = RS_BUSY;
            tick();
            chk($sformatf("alt%0d_ramaddr_held", k), ramaddr, exp_addr);
            ramstate = RS_ACCESS; ramload = 32'(k + 1); #1;
            chk($sformatf("alt%0d_iwait", k), 32'(iwait), is_d ? 32'd1 : 32'd0);
            chk($sformatf("alt%0d_dwait", k), 32'(dwait), is_d ? 32'd0 : 32'd1);
            chk($sformatf("alt%0d_load", k), is_d ? dload : iload, 32'(k + 1));
            tick();
            ramstate = RS_FREE; ramload = '0;
            tick();
        end
        iREN = 1'b0; dREN = 1'b0;

        // Timeout: RAM stays BUSY forever
        dREN = 1'b1; daddr = 32'h300;
        tick();
        ramstate = RS_BUSY;
        early = 0;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (dwait !== 1'b1) early++;
            tick();
        end
        #1;
        chk("to_early_done", 32'(early), 32'd0);
        chk("to_dwait", 32'(dwait), 32'd0);
        chk("to_dload", dload, BAD_VAL);
        dREN = 1'b0;
        tick();
        ramstate = RS_FREE; #1;
        chk("to_err", 32'(err), 32'd1);
        chk("to_gap_ramREN", 32'(ramREN), 32'd0);
        tick();
        iREN = 1'b1; iaddr = 32'h10;
        tick();
        ramstate = RS_BUSY;
        tick();
        ramstate = RS_ACCESS; ramload = 32'h55; #1;
        chk("to_good_iwait", 32'(iwait), 32'd0);
        chk("to_good_iload", iload, 32'h55);
        iREN = 1'b0;
        tick();
        ramstate = RS_FREE; ramload = '0; #1;
        chk("to_err_sticky", 32'(err), 32'd1);
        tick();

        // ERROR in the 2nd SERVE_I cycle
        RST = 1'b1;
        tick();
        RST = 1'b0; #1;
        chk("er_err_clr", 32'(err), 32'd0);
        iREN = 1'b1; iaddr = 32'h400;
        tick();
        chk("er_ramREN", 32'(ramREN), 32'd1);
        ramstate = RS_BUSY; #1;
        chk("er_iwait_busy", 32'(iwait), 32'd1);
        tick();
        ramstate = RS_ERROR; #1;
        chk("er_iwait", 32'(iwait), 32'd0);
        chk("er_iload", iload, BAD_VAL);
        chk("er_dwait", 32'(dwait), 32'd1);
        tick();
        ramstate = RS_FREE; #1;
        chk("er_err", 32'(err), 32'd1);
        chk("er_gap_ramREN", 32'(ramREN), 32'd0);
        tick();
        chk("er_idle_ramREN", 32'(ramREN), 32'd0);
        tick();
        chk("er_regrant_ramREN", 32'(ramREN), 32'd1);
        chk("er_regrant_addr", ramaddr, 32'h400);
        ramstate = RS_ACCESS; ramload = 32'h77; #1;
        chk("er_regrant_iload", iload, 32'h77);
        iREN = 1'b0;
        tick();
        ramstate = RS_FREE; ramload = '0;
        tick();

        // Reset in the middle of SERVE_D
        dREN = 1'b1; daddr = 32'h500;
        tick();
        chk("mr_ramREN", 32'(ramREN), 32'd1);
        ramstate = RS_BUSY;
        tick();
        RST = 1'b1; #1;
        chk("mr_dwait_in_rst", 32'(dwait), 32'd1);
        tick();
        chk("mr_ramREN", 32'(ramREN), 32'd0);
        chk("mr_ramWEN", 32'(ramWEN), 32'd0);
        chk("mr_err", 32'(err), 32'd0);
        chk("mr_ramaddr", ramaddr, 32'd0);
        RST = 1'b0; dREN = 1'b0; iREN = 1'b1; iaddr = 32'h600; ramstate = RS_FREE;
        tick();
        chk("mr_i_ramREN", 32'(ramREN), 32'd1);
        chk("mr_i_ramaddr", ramaddr, 32'h600);
        ramstate = RS_BUSY;
        tick();
        ramstate = RS_ACCESS; ramload = 32'hCAFE_F00D; #1;
        chk("mr_i_iwait", 32'(iwait), 32'd0);
        chk("mr_i_iload", iload, 32'hCAFE_F00D);
        chk("mr_i_dwait", 32'(dwait), 32'd1);
        iREN = 1'b0;
        tick();
        ramstate = RS_FREE; ramload = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks_q, failures_q);
        $finish;
    end

    // Both waits low together is never legal.
    always @(negedge CLK) begin
        if (!RST && !iwait && !dwait) begin
            failures_q++;
            $display("FAIL both_waits_low got=iwait0,dwait0 exp=at most one low");
        end
    end

endmodule
